// File: rtl/tpn_pkg.sv
// Shared constants and types for the true-page-number (TPN) list path.
// Used by the bit-pattern matcher (producer) and the list reader (consumer).
//   tpn_t          : one global page number, 0..NOP-1
//   cnt_t          : list entry count, 0..NOP (one bit wider than tpn_t)
//   tpn_list_t     : packed list, entry i at [i*NOP_WIDTH +: NOP_WIDTH]
//   reader_state_e : list reader FSM states
package tpn_pkg;

  localparam int NOP       = 24;  // total pages in the array (max list entries)
  localparam int NOP_WIDTH = 5;   // bits per list entry
  localparam int PPB       = 8;   // pages per block (power of two)
  localparam int PPB_WIDTH = 3;   // log2(PPB)
  localparam int NOB       = NOP / PPB;  // number of blocks
  localparam int NOB_WIDTH = 2;   // bits for block index

  typedef logic [NOP_WIDTH-1:0]     tpn_t;
  typedef logic [NOP_WIDTH:0]       cnt_t;
  typedef logic [NOP*NOP_WIDTH-1:0] tpn_list_t;

  localparam cnt_t NOP_CNT = cnt_t'(NOP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FIN    = 2'd2
  } reader_state_e;

  // Extract entry idx from a packed list.
  function automatic tpn_t list_entry(input tpn_list_t list, input int idx);
    return list[idx*NOP_WIDTH +: NOP_WIDTH];
  endfunction

endpackage

// File: rtl/tpn_list_reader_if.sv
// Bundle of the load side and the streaming side of the TPN list reader.
//   load, g_tpn_arr, g_tpn_cnt : list capture request (from matcher side)
//   out_ready                  : downstream accepts the presented entry
//   busy, out_valid, out_tpn, out_blk, out_off, out_last, done, err :
//                                reader status and streamed entry
// modport master : the environment driving loads and consuming entries
// modport slave  : the list reader itself
interface tpn_list_reader_if
  import tpn_pkg::*;
();

  logic                 load;
  tpn_list_t            g_tpn_arr;
  cnt_t                 g_tpn_cnt;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  tpn_t                 out_tpn;
  logic [NOB_WIDTH-1:0] out_blk;
  logic [PPB_WIDTH-1:0] out_off;
  logic                 out_last;
  logic                 done;
  logic                 err;

  modport master (
    output load, g_tpn_arr, g_tpn_cnt, out_ready,
    input  busy, out_valid, out_tpn, out_blk, out_off, out_last, done, err
  );

  modport slave (
    input  load, g_tpn_arr, g_tpn_cnt, out_ready,
    output busy, out_valid, out_tpn, out_blk, out_off, out_last, done, err
  );

endinterface

// File: rtl/tpn_list_check.sv
// Combinational format checker for a packed TPN list.
//   list        : packed list of NOP entries
//   cnt         : requested entry count (may exceed NOP)
//   cnt_clamped : min(cnt, NOP)
//   err_next    : 1 if cnt > NOP, any valid entry >= NOP, or valid entries
//                 are not strictly ascending
module tpn_list_check
  import tpn_pkg::*;
(
  input  tpn_list_t list,
  input  cnt_t      cnt,
  output cnt_t      cnt_clamped,
  output logic      err_next
);

  logic over_cnt;

  // NOTE: combinational logic uses blocking assignments, and every output
  // gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    over_cnt    = (cnt > NOP_CNT);
    cnt_clamped = over_cnt ? NOP_CNT : cnt;
    err_next    = over_cnt;

    // Range check over valid entries only; entries past the count are
    // don't-care.
    for (int i = 0; i < NOP; i++) begin
      if (cnt_t'(i) < cnt_clamped && {1'b0, list_entry(list, i)} >= NOP_CNT)
        err_next = 1'b1;
    end

    // Strictly ascending: entry i must exceed entry i-1 whenever both are valid.
    for (int i = 1; i < NOP; i++) begin
      if (cnt_t'(i) < cnt_clamped && list_entry(list, i) <= list_entry(list, i-1))
        err_next = 1'b1;
    end
  end

endmodule

// File: rtl/tpn_list_reader.sv
// TPN list reader: consumer end of the pattern-match result interface.
// Captures the packed global TPN list on a load pulse (only when idle) and
// streams entries one per valid/ready handshake, each split into block index
// and in-block page offset, with last/done signalling and a sticky format
// error flag.
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : tpn_list_reader_if.slave (load/list inputs, streamed outputs)
module tpn_list_reader
  import tpn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  tpn_list_reader_if.slave  bus
);

  reader_state_e state_q, state_d;

  tpn_t snap_q [NOP];  // captured list
  cnt_t cnt_q;         // clamped entry count
  tpn_t idx_q;         // index of the entry currently presented
  tpn_t out_tpn_q;
  logic out_last_q;
  logic err_q;

  cnt_t cnt_clamped;
  logic err_next;

  logic out_valid_c, busy_c, done_c;
  logic load_acc, beat;
  tpn_t idx_nxt;

  tpn_list_check u_check (
    .list        (bus.g_tpn_arr),
    .cnt         (bus.g_tpn_cnt),
    .cnt_clamped (cnt_clamped),
    .err_next    (err_next)
  );

  // A load is only honoured when idle; loads while busy are dropped.
  assign load_acc = bus.load && (state_q == IDLE);
  assign beat     = out_valid_c && bus.out_ready;
  assign idx_nxt  = idx_q + tpn_t'(1);

  // ---------------------------------------------------------------- state reg
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.load) state_d = (cnt_clamped == '0) ? FIN : STREAM;
      STREAM:  if (bus.out_ready && out_last_q) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------------- state output
  always_comb begin
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    done_c      = 1'b0;
    unique case (state_q)
      IDLE:    ;
      STREAM:  begin out_valid_c = 1'b1; busy_c = 1'b1; end
      FIN:     begin done_c      = 1'b1; busy_c = 1'b1; end
      default: ;
    endcase
  end

  // ------------------------------------------------------------ list snapshot
  // NOTE: the snapshot array is data-only and is not reset; it is never read
  // unless a load has just refilled it, so clearing it would only cost logic.
  always_ff @(posedge clk) begin
    if (load_acc) begin
      for (int i = 0; i < NOP; i++) snap_q[i] <= list_entry(bus.g_tpn_arr, i);
    end
  end

  // --------------------------------------------------------- stream datapath
  // The presented entry is registered: on load entry 0 comes straight from
  // the input bus, on each handshake the next one comes from the snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      out_tpn_q  <= '0;
      out_last_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (load_acc) begin
      cnt_q      <= cnt_clamped;
      idx_q      <= '0;
      out_tpn_q  <= list_entry(bus.g_tpn_arr, 0);
      out_last_q <= (cnt_clamped == cnt_t'(1));
      err_q      <= err_next;
    end else if (beat) begin
      if (out_last_q) begin
        out_last_q <= 1'b0;
      end else begin
        idx_q      <= idx_nxt;
        out_tpn_q  <= snap_q[idx_nxt];
        // Next entry is last when idx_nxt == cnt-1.
        out_last_q <= ((cnt_t'(idx_q) + cnt_t'(2)) == cnt_q);
      end
    end
  end

  assign bus.busy      = busy_c;
  assign bus.out_valid = out_valid_c;
  assign bus.done      = done_c;
  assign bus.err       = err_q;
  assign bus.out_tpn   = out_tpn_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_blk   = out_tpn_q[NOP_WIDTH-1:PPB_WIDTH];
  assign bus.out_off   = out_tpn_q[PPB_WIDTH-1:0];

endmodule
